// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared encodings for the RV32I multicycle controller: opcodes,
//             immediate formats, FSM states, instruction classes, ALU ops,
//             writeback and next-PC selects.
//  Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CL_LOAD    = 4'd0,
    CL_STORE   = 4'd1,
    CL_BRANCH  = 4'd2,
    CL_OP_IMM  = 4'd3,
    CL_OP      = 4'd4,
    CL_LUI     = 4'd5,
    CL_AUIPC   = 4'd6,
    CL_JAL     = 4'd7,
    CL_JALR    = 4'd8,
    CL_FENCE   = 4'd9,
    CL_ILLEGAL = 4'd10
  } cls_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers gate it
  function automatic logic [3:0] alu_op_from_funct(input logic [2:0] funct3,
                                                   input logic       alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_decode
//  Purpose  : Combinational instruction decode: class, immediate format,
//             illegal-encoding flag and ALU operation from the IR.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_decode
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output cls_e        o_cls,
  output imm_sel_e    o_imm_sel,
  output logic        o_illegal,
  output logic [3:0]  o_alu_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       bad_branch;
  logic       unused_instr_bits;

  assign opcode    = i_instr[6:0];
  assign funct3    = i_instr[14:12];
  assign funct7_b5 = i_instr[30];
  assign unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

  // Opcode to class / immediate format / ALU operation
  always_comb begin
    o_cls      = CL_ILLEGAL;
    o_imm_sel  = IMM_I;
    o_alu_op   = ALU_ADD;
    bad_branch = 1'b0;
    case (opcode)
      OPC_LOAD:   o_cls = CL_LOAD;
      OPC_STORE:  begin o_cls = CL_STORE; o_imm_sel = IMM_S; end
      OPC_BRANCH: begin
        o_cls      = CL_BRANCH;
        o_imm_sel  = IMM_B;
        bad_branch = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_OP_IMM: begin
        o_cls = CL_OP_IMM;
        // bit 30 is immediate data except on SRAI
        o_alu_op = alu_op_from_funct(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OPC_OP: begin
        o_cls    = CL_OP;
        o_alu_op = alu_op_from_funct(funct3, funct7_b5);
      end
      OPC_LUI:    begin o_cls = CL_LUI;   o_imm_sel = IMM_U; end
      OPC_AUIPC:  begin o_cls = CL_AUIPC; o_imm_sel = IMM_U; end
      OPC_JAL:    begin o_cls = CL_JAL;   o_imm_sel = IMM_J; end
      OPC_JALR:   o_cls = CL_JALR;
      OPC_FENCE:  o_cls = CL_FENCE;
      default:    o_cls = CL_ILLEGAL;
    endcase
    o_illegal = (o_cls == CL_ILLEGAL) || bad_branch;
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multicycle RV32I control FSM. Sequences FETCH/DECODE/EXEC/MEM/
//             WB, handshakes with the unified memory port and drives all
//             datapath controls. Retires one instruction per pass.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl
  import rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_br_eq,
  input  logic        i_br_lt,
  input  logic        i_br_ltu,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic        o_ir_we,
  output logic [2:0]  o_imm_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic [1:0]  o_pc_sel,
  output logic        o_pc_we,
  output logic        o_illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  cls_e       dec_cls;
  imm_sel_e   dec_imm_sel;
  logic       dec_illegal;
  logic [3:0] dec_alu_op;
  logic       br_taken;
  logic       drive_dp;

  mc_decode u_decode (
    .i_instr   (i_instr),
    .o_cls     (dec_cls),
    .o_imm_sel (dec_imm_sel),
    .o_illegal (dec_illegal),
    .o_alu_op  (dec_alu_op)
  );

  // Branch condition from funct3 and the comparator flags
  always_comb begin
    br_taken = 1'b0;
    case (i_instr[14:12])
      3'b000:  br_taken = i_br_eq;
      3'b001:  br_taken = !i_br_eq;
      3'b100:  br_taken = i_br_lt;
      3'b101:  br_taken = !i_br_lt;
      3'b110:  br_taken = i_br_ltu;
      3'b111:  br_taken = !i_br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // State register and sticky illegal flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_START;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d        = state_q;
    illegal_d      = illegal_q;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr_sel = 1'b0;
    o_ir_we        = 1'b0;
    o_imm_sel      = IMM_I;
    o_alu_a_sel    = 1'b0;
    o_alu_b_sel    = 1'b0;
    o_alu_op       = ALU_ADD;
    o_rf_we        = 1'b0;
    o_wb_sel       = WB_ALU;
    o_pc_sel       = PC_PLUS4;
    o_pc_we        = 1'b0;
    drive_dp       = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_we = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        o_imm_sel = dec_imm_sel;
        if (dec_illegal) begin
          state_d   = ST_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        drive_dp = 1'b1;
        case (dec_cls)
          CL_BRANCH: begin
            o_pc_we  = 1'b1;
            o_pc_sel = br_taken ? PC_IMM : PC_PLUS4;
            state_d  = ST_FETCH;
          end
          CL_FENCE: begin
            o_pc_we = 1'b1;
            state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        // ALU controls stay driven so the address is stable while waiting
        drive_dp       = 1'b1;
        o_mem_req      = 1'b1;
        o_mem_addr_sel = 1'b1;
        o_mem_we       = (dec_cls == CL_STORE);
        if (i_mem_ready) begin
          if (dec_cls == CL_STORE) begin
            o_pc_we = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        drive_dp = 1'b1;
        o_rf_we  = 1'b1;
        o_pc_we  = 1'b1;
        state_d  = ST_FETCH;
        case (dec_cls)
          CL_LUI:  o_wb_sel = WB_IMM;
          CL_LOAD: o_wb_sel = WB_MEM;
          CL_JAL:  begin o_wb_sel = WB_PC4; o_pc_sel = PC_IMM; end
          CL_JALR: begin o_wb_sel = WB_PC4; o_pc_sel = PC_ALU; end
          default: o_wb_sel = WB_ALU;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START;
    endcase
    if (drive_dp) begin
      o_imm_sel   = dec_imm_sel;
      o_alu_a_sel = (dec_cls == CL_AUIPC);
      o_alu_b_sel = !((dec_cls == CL_OP) || (dec_cls == CL_BRANCH));
      o_alu_op    = dec_alu_op;
    end
  end

  assign o_illegal = illegal_q;

endmodule
`default_nettype wire
